// File: rtl/bit_serial_adder_ctrl.sv
// Sequencer for one external single-bit full-adder cell: adds or subtracts two
// WIDTH-bit operands one bit per clock, LSB first, with a start/busy/done handshake.
module bit_serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_carry
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last_bit;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_bit  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last_bit  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN) || (state == DONE);
  assign done = (state == DONE);
  assign fa_a = (state == RUN) & a_sh[0];
  assign fa_b = (state == RUN) & b_sh[0];
  assign fa_c = (state == RUN) & carry;

  // The result registers are loaded on the edge that enters DONE, taking the
  // last sum bit straight from the cell so they are already valid while done is high.
  // The carry held during the last bit is the carry into the MSB, which gives overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sh  <= op_a;
      b_sh  <= sub ? ~op_b : op_b;
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      carry  <= fa_carry;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        sum  <= {fa_sum, res_sh[WIDTH-1:1]};
        cout <= fa_carry;
        ovf  <= carry ^ fa_carry;
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Self-checking bench for bit_serial_adder_ctrl: directed corner cases, start-while-busy,
// mid-run reset and 1000 back-to-back random add/sub operations against an arithmetic model.
module tb_bit_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             fa_a;
  logic             fa_b;
  logic             fa_c;
  logic             fa_sum;
  logic             fa_carry;

  int nAsserts = 0;
  int nFails   = 0;

  bit_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c),
    .fa_sum(fa_sum), .fa_carry(fa_carry)
  );

  // Reference full-adder cell on the datapath side
  assign fa_sum   = fa_a ^ fa_b ^ fa_c;
  assign fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {ovf, cout, sum} computed from whole-number arithmetic
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic c, input logic s);
    int sa, sb, r, u;
    logic co, ov;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      r  = sa - sb;
      u  = int'(a) - int'(b);
      co = (a >= b);
    end else begin
      r  = sa + sb + int'(c);
      u  = int'(a) + int'(b) + int'(c);
      co = (u > 255);
    end
    ov = (r > 127) || (r < -128);
    return {ov, co, u[WIDTH-1:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one start pulse and returns at the next negedge
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic c, input logic s);
    op_a  = a;
    op_b  = b;
    cin   = c;
    sub   = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic runDirected(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic c, input logic s);
    logic [WIDTH+1:0] exp;
    int cycles;
    exp = model(a, b, c, s);
    applyStimulus(a, b, c, s);
    cycles = 1;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'd9);
    checkOutput({tag, "_sum"}, 32'(sum), 32'(exp[WIDTH-1:0]));
    checkOutput({tag, "_cout"}, 32'(cout), 32'(exp[WIDTH]));
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'(exp[WIDTH+1]));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_hold_sum"}, 32'(sum), 32'(exp[WIDTH-1:0]));
  endtask

  initial begin
    logic [WIDTH+1:0] exp;
    logic [WIDTH-1:0] ra, rb;
    logic rc, rs;
    int busyCnt, doneCnt, opsDone, cyc, prevDone;

    rst = 1'b1; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_sum", 32'(sum), 32'd0);
    checkOutput("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
    checkOutput("rst_fa", 32'({fa_a, fa_b, fa_c}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed add/sub corner cases");
    runDirected("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0);
    runDirected("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    runDirected("add_00_00_c", 8'h00, 8'h00, 1'b1, 1'b0);
    runDirected("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1);
    runDirected("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1);
    checkOutput("idle_fa", 32'({fa_a, fa_b, fa_c}), 32'd0);

    $display("[TB] start pulses while busy");
    exp = model(8'h12, 8'h34, 1'b0, 1'b0);
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0);
    busyCnt = 0;
    doneCnt = 0;
    for (int i = 1; i <= 12; i++) begin
      busyCnt += int'(busy);
      doneCnt += int'(done);
      if (i == 3 || i == 6) begin
        op_a  = 8'($urandom);
        op_b  = 8'($urandom);
        sub   = 1'($urandom);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput("busy_start_busycnt", 32'(busyCnt), 32'd9);
    checkOutput("busy_start_donecnt", 32'(doneCnt), 32'd1);
    checkOutput("busy_start_sum", 32'(sum), 32'(exp[WIDTH-1:0]));
    checkOutput("busy_start_flags", 32'({ovf, cout}), 32'({exp[WIDTH+1], exp[WIDTH]}));

    $display("[TB] reset in the middle of a run");
    applyStimulus(8'hC3, 8'h5E, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_sum", 32'(sum), 32'd0);
    checkOutput("midrst_flags", 32'({done, cout, ovf}), 32'd0);
    checkOutput("midrst_fa", 32'({fa_a, fa_b, fa_c}), 32'd0);
    doneCnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      doneCnt += int'(done);
    end
    checkOutput("midrst_no_done", 32'(doneCnt), 32'd0);
    runDirected("after_rst", 8'hA7, 8'h6B, 1'b0, 1'b0);

    $display("[TB] back-to-back random operations");
    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
    exp = model(ra, rb, rc, rs);
    op_a = ra; op_b = rb; cin = rc; sub = rs;
    start = 1'b1;
    opsDone = 0;
    cyc = 0;
    prevDone = 0;
    while (opsDone < 1000 && cyc < 12000) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        checkOutput("b2b_sum", 32'(sum), 32'(exp[WIDTH-1:0]));
        checkOutput("b2b_cout", 32'(cout), 32'(exp[WIDTH]));
        checkOutput("b2b_ovf", 32'(ovf), 32'(exp[WIDTH+1]));
        checkOutput("b2b_interval", 32'(cyc - prevDone), (opsDone == 0) ? 32'd9 : 32'd10);
        prevDone = cyc;
        opsDone++;
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
        exp = model(ra, rb, rc, rs);
        op_a = ra; op_b = rb; cin = rc; sub = rs;
      end
    end
    start = 1'b0;
    checkOutput("b2b_count", 32'(opsDone), 32'd1000);
    repeat (3) @(negedge clk);
    checkOutput("final_idle", 32'({busy, done}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
